// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter-legality checks for the parametrised FIFO.
package fifo_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_level, input int ae_level);
        return (data_w >= 1) && (depth >= 4) && is_pow2(depth)
            && (af_level >= 1) && (af_level <= depth - 1)
            && (ae_level >= 0) && (ae_level <= depth - 2)
            && (ae_level < af_level);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read port that holds its last word.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Storage is left uninitialised; only the output register is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy count, registered flags and sticky errors
// around a dual-port RAM whose registered read port drives data_out.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     read_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_LEVEL);

    generate
        if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
            $error("fifo_param: DEPTH must be a power of 2 >= 4 and AE_LEVEL < AF_LEVEL within range");
        end
    endgenerate

    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]  count_d, count_q;
    logic              full_d, full_q;
    logic              empty_d, empty_q;
    logic              almost_full_d, almost_full_q;
    logic              almost_empty_d, almost_empty_q;
    logic              data_valid_d, data_valid_q;
    logic              overflow_d, overflow_q;
    logic              underflow_d, underflow_q;

    always_comb begin
        wr_acc   = write_en & ~full_q;
        rd_acc   = read_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + ADDR_W'(rd_acc);
        count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

        // Flags come from the next count so they move on the same edge as count.
        full_d         = (count_d == FULL_LVL);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_LVL);
        almost_empty_d = (count_d <= AE_LVL);
        data_valid_d   = rd_acc;

        // Setting an error wins over clearing it in the same cycle.
        overflow_d = overflow_q;
        if (err_clr) overflow_d = 1'b0;
        if (write_en & full_q) overflow_d = 1'b1;

        underflow_d = underflow_q;
        if (err_clr) underflow_d = 1'b0;
        if (read_en & empty_q) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            data_valid_q   <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            data_valid_q   <= data_valid_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    assign data_valid   = data_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
